alu_mul_seq: RTL and testbench

- Multi-cycle multiply sequencer that time-shares the 32-bit ALU to compute a 64-bit product by shift-add.
- Owns the ALU operand and select lines while busy; ALU result and add carry are fed back.
- Sits beside the ALU in the execute stage and serves MULT/MULTU.
- Produces {product_hi, product_lo} with a start/busy/done handshake.

---
 rtl/alu_mul_seq.sv | 168 ++++++++++++++++
 tb/tb_alu_mul_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_seq.sv
// Shift-add 32x32 multiply sequencer that borrows the execute-stage ALU while busy.
// Define MUL_SIGNED_EN to add the mult_signed port and the signed MULT path.
module alu_mul_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
`ifdef MUL_SIGNED_EN
  input  logic             mult_signed,
`endif
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_s0,
  output logic             alu_s1,
  output logic             alu_s2,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_cout_add,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CALC  = 3'd1;
  localparam logic [2:0] DONE  = 3'd2;
  localparam logic [2:0] SEL_AND = 3'b000;
  localparam logic [2:0] SEL_ADD = 3'b010;
`ifdef MUL_SIGNED_EN
  localparam logic [2:0] NEGA  = 3'd3;
  localparam logic [2:0] NEGB  = 3'd4;
  localparam logic [2:0] FIXLO = 3'd5;
  localparam logic [2:0] FIXHI = 3'd6;
  localparam logic [2:0] SEL_SUB = 3'b100;
  localparam logic [2:0] SEL_NOR = 3'b111;
`endif

  logic [2:0]       state;
  logic [WIDTH-1:0] mcand, hi, lo;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       sel;
`ifdef MUL_SIGNED_EN
  logic             sgn_mode, sign_a, sign_b, lo_zero;
`endif

  assign product_hi = hi;
  assign product_lo = lo;
  assign {alu_s0, alu_s1, alu_s2} = sel;

  always_comb begin
    alu_a = '0;
    alu_b = '0;
    sel   = SEL_AND;
    case (state)
      CALC: begin
        alu_a = hi;
        alu_b = mcand;
        sel   = SEL_ADD;
      end
`ifdef MUL_SIGNED_EN
      NEGA: begin
        alu_b = mcand;
        sel   = SEL_SUB;
      end
      NEGB, FIXLO: begin
        alu_b = lo;
        sel   = SEL_SUB;
      end
      // 64-bit negate: hi gets -hi when the low word borrowed nothing, else ~hi
      FIXHI: begin
        alu_b = hi;
        if (lo_zero) begin
          sel = SEL_SUB;
        end else begin
          alu_a = hi;
          sel   = SEL_NOR;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef MUL_SIGNED_EN
      sgn_mode <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      lo_zero  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        // The done-pulse cycle is seen as DONE from outside, so a start there is dropped.
        IDLE: if (start && !done) begin
          mcand <= op_a;
          lo    <= op_b;
          hi    <= '0;
          cnt   <= '0;
          busy  <= 1'b1;
`ifdef MUL_SIGNED_EN
          sgn_mode <= mult_signed;
          state    <= mult_signed ? NEGA : CALC;
`else
          state <= CALC;
`endif
        end
        CALC: begin
          if (lo[0]) begin
            hi <= {alu_cout_add, alu_res[WIDTH-1:1]};
            lo <= {alu_res[0], lo[WIDTH-1:1]};
          end else begin
            hi <= {1'b0, hi[WIDTH-1:1]};
            lo <= {hi[0], lo[WIDTH-1:1]};
          end
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH-1)) begin
`ifdef MUL_SIGNED_EN
            state <= sgn_mode ? FIXLO : DONE;
`else
            state <= DONE;
`endif
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
`ifdef MUL_SIGNED_EN
        NEGA: begin
          sign_a <= mcand[WIDTH-1];
          if (mcand[WIDTH-1]) mcand <= alu_res;
          state <= NEGB;
        end
        NEGB: begin
          sign_b <= lo[WIDTH-1];
          if (lo[WIDTH-1]) lo <= alu_res;
          state <= CALC;
        end
        FIXLO: begin
          if (sign_a ^ sign_b) lo <= alu_res;
          lo_zero <= (lo == '0);
          state   <= FIXHI;
        end
        FIXHI: begin
          if (sign_a ^ sign_b) hi <= alu_res;
          state <= DONE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq: random and directed multiplies against an
// arithmetic product model, with a behavioural ALU closing the feedback loop.
module tb_alu_mul_seq;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [31:0] op_a = '0, op_b = '0;
`ifdef MUL_SIGNED_EN
  logic        mult_signed = 1'b0;
`endif
  logic [31:0] alu_a, alu_b, alu_res, product_hi, product_lo;
  logic        alu_s0, alu_s1, alu_s2, alu_cout_add, busy, done;
  logic [2:0]  sel;
  logic [32:0] sum33;

  alu_mul_seq #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
`ifdef MUL_SIGNED_EN
    .mult_signed(mult_signed),
`endif
    .alu_a(alu_a), .alu_b(alu_b), .alu_s0(alu_s0), .alu_s1(alu_s1), .alu_s2(alu_s2),
    .alu_res(alu_res), .alu_cout_add(alu_cout_add), .busy(busy), .done(done),
    .product_hi(product_hi), .product_lo(product_lo)
  );

  always #5 clk = ~clk;

  assign sel = {alu_s0, alu_s1, alu_s2};

  // Execute-stage ALU as the sequencer expects to see it
  always_comb begin
    sum33        = {1'b0, alu_a} + {1'b0, alu_b};
    alu_cout_add = sum33[32];
    alu_res      = '0;
    case (sel)
      3'b000: alu_res = alu_a & alu_b;
      3'b001: alu_res = alu_a | alu_b;
      3'b010: alu_res = sum33[31:0];
      3'b011: alu_res = alu_a ^ alu_b;
      3'b100: alu_res = alu_a - alu_b;
      3'b101: alu_res = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      3'b110: alu_res = alu_a << alu_b[4:0];
      default: alu_res = ~(alu_a | alu_b);
    endcase
  end

  typedef struct { logic [63:0] prod; int lat; int t0; } exp_t;
  exp_t sbq[$];
  int n_cmp = 0, n_bad = 0, n_push = 0, n_done = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input bit s);
    longint pa, pb;
    if (s) begin
      pa = longint'($signed(a));
      pb = longint'($signed(b));
      return 64'(pa * pb);
    end
    return 64'(a) * 64'(b);
  endfunction

  task automatic push(input logic [31:0] a, input logic [31:0] b, input bit s, input int t0);
    exp_t e;
    e.prod = model(a, b, s);
    e.lat  = s ? 37 : 33;
    e.t0   = t0;
    sbq.push_back(e);
    n_push++;
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while ((busy || done) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) check("idle_timeout", 1, 0);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit s);
    wait_idle();
    op_a = a;
    op_b = b;
`ifdef MUL_SIGNED_EN
    mult_signed = s;
`endif
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    push(a, b, s, cyc);
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 0);
    check({tag, "_done"}, 64'(done), 0);
    check({tag, "_product"}, {product_hi, product_lo}, 0);
    check({tag, "_alu_ops"}, {alu_a, alu_b}, 0);
    check({tag, "_alu_sel"}, 64'(sel), 0);
  endtask

  // Monitor: pops one expectation per done pulse
  initial begin
    int busy_cnt = 0, add_cnt = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_cnt = 0;
        add_cnt  = 0;
      end else begin
        if (busy) begin
          busy_cnt++;
          if (sel == 3'b010) add_cnt++;
        end
        if (done) begin
          n_done++;
          if (sbq.size() == 0) begin
            check("spurious_done", 1, 0);
          end else begin
            e = sbq.pop_front();
            check("product", {product_hi, product_lo}, e.prod);
            check("latency", 64'(cyc - e.t0), 64'(e.lat));
            check("busy_cycles", 64'(busy_cnt), 64'(e.lat));
            check("add_cycles", 64'(add_cnt), 32);
          end
          busy_cnt = 0;
          add_cnt  = 0;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, pending=%0d", sbq.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, k;
    logic [31:0] a2, b2;
    #1;
    chk_zero("reset");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    issue(32'd3, 32'd5, 1'b0);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

    // Start re-asserted mid-operation with different operands must be ignored
    issue(32'h1234_5678, 32'h0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    op_a = $urandom; op_b = $urandom | 32'h1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;

    // Abort at CALC cycle 10; no done may follow
    issue(32'd7, 32'd9, 1'b0);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_zero("abort");
    void'(sbq.pop_back());
    n_push--;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    issue(32'd6, 32'd7, 1'b0);

    // Start held high: ignored in the done-pulse cycle, accepted in the next idle one
    wait_idle();
    op_a = $urandom; op_b = $urandom; start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    push(op_a, op_b, 1'b0, t0);
    a2 = $urandom; b2 = $urandom;
    op_a = a2; op_b = b2;
    repeat (35) @(posedge clk);
    #1 start = 1'b0;
    push(a2, b2, 1'b0, t0 + 35);

    for (int i = 0; i < 16; i++) begin
      case (i % 4)
        0: issue($urandom, $urandom, 1'b0);
        1: issue($urandom_range(0, 255), $urandom, 1'b0);
        2: issue(32'h8000_0000 | $urandom, 32'hFFFF_0000 | $urandom, 1'b0);
        default: issue($urandom, 32'h0000_0001 << $urandom_range(0, 31), 1'b0);
      endcase
    end

`ifdef MUL_SIGNED_EN
    issue(32'hFFFF_FFFD, 32'd5, 1'b1);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue(32'hFFFF_FFFF, 32'd0, 1'b1);
    for (int i = 0; i < 12; i++) issue($urandom, $urandom, bit'($urandom_range(0, 1)));
`endif

    k = 0;
    while (sbq.size() != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    repeat (3) @(posedge clk);
    check("pending_after_drain", 64'(sbq.size()), 0);
    check("done_count", 64'(n_done), 64'(n_push));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
